dual_issue_sequencer: RTL and testbench
=======================================

Name: dual_issue_sequencer

Overview:
Consumes the decode-stage slot pair of the dual-issue core and produces the per-cycle issue and stall controls that act on an intra-pair dependency.
- Pair independent: both slots issue together.
- Slot 2 depends on slot 1: the pair is split over two cycles. Slot 1 issues first while slot 2 and fetch hold, then slot 2 issues alone with a bubble in slot 1.
- Sits between the decode registers of pipelines 1/2 and the execute stage.
- Also drives the fetch stall and a split performance counter.

Parameters:
REG_AW, 5, register-index width
CNT_W, 16, width of saturating split counter

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
ValidD1  in  1  decode slot 1 holds a valid instruction
ValidD2  in  1  decode slot 2 holds a valid instruction
RegWriteD1  in  1  slot 1 writes a register
RdD1  in  REG_AW  slot 1 destination
RegWriteD2  in  1  slot 2 writes a register
RdD2  in  REG_AW  slot 2 destination
Rs1D2  in  REG_AW  slot 2 source 1
Rs2D2  in  REG_AW  slot 2 source 2
UsesRs1D2  in  1  slot 2 reads Rs1D2
UsesRs2D2  in  1  slot 2 reads Rs2D2
StallExt  in  1  downstream stall (load-use, memory wait)
Flush  in  1  branch/jump redirect; decode contents discarded this cycle
IssueP1  out  1  slot 1 enters execute this cycle (0 = bubble)
IssueP2  out  1  slot 2 enters execute this cycle (0 = bubble)
StallPipeline1  out  1  hold decode register of pipeline 1
StallPipeline2  out  1  hold decode register of pipeline 2
StallFetch  out  1  hold PC/fetch registers
SplitCount  out  CNT_W  number of pairs split since reset

Behaviour:
- Hazard, combinational:
  - dep = ValidD1 & ValidD2 & RegWriteD1 & (RdD1 != 0) & (RAW1 | RAW2 | WAW).
  - RAW1 = UsesRs1D2 & (Rs1D2 == RdD1).
  - RAW2 = UsesRs2D2 & (Rs2D2 == RdD1).
  - WAW = RegWriteD2 & (RdD2 == RdD1).
  - x0 is never a dependency.
- States: PAIR (reset state), SPLIT.
- Output priority, all outputs combinational from state and inputs:
  1. rst = 1: all outputs 0, state = PAIR, SplitCount = 0.
  2. Flush: Issue* = 0, Stall* = 0; next state = PAIR.
  3. StallExt: Issue* = 0, StallPipeline1 = StallPipeline2 = StallFetch = 1; state holds; counter holds.
  4. PAIR, !dep: IssueP1 = ValidD1, IssueP2 = ValidD2, stalls 0; stay PAIR.
  5. PAIR, dep: IssueP1 = 1, IssueP2 = 0, StallPipeline2 = 1, StallFetch = 1, StallPipeline1 = 0; next SPLIT; SplitCount += 1, saturating at all-ones.
  6. SPLIT: IssueP1 = 0, IssueP2 = ValidD2, StallPipeline1 = 1, StallPipeline2 = 0, StallFetch = 0; next PAIR unconditionally.
- Timing:
  - Latency per split pair = 2 cycles.
  - Back-to-back dependent pairs: PAIR -> SPLIT -> PAIR -> SPLIT; no idle cycle in between.
  - dep is not evaluated in SPLIT.
- Simultaneous events:
  - Flush and StallExt together: Flush wins.
  - Flush during SPLIT: the held slot 2 is dropped (IssueP2 = 0) and state returns to PAIR.
- Async reset mid-SPLIT: state returns to PAIR immediately; outputs go to 0 while rst is high.
- Slot validity:
  - Only slot 1 valid: issue slot 1 alone, no split.
  - Only slot 2 valid: issue slot 2 alone, no split.
- SplitCount is registered; it updates on the clk edge that ends a rule-5 cycle.

Decomposition:
- Shared package `dual_issue_pkg`:
  - enum seq_state_t {PAIR, SPLIT}.
  - REG_ZERO constant.
  - REG_AW default.
- One natural combinational sub-module: `pair_hazard_detect` (slot fields in, dep plus RAW/WAW flags out), reusable by the forwarding logic.
- FSM, output decode and counter stay in `dual_issue_sequencer`.

Test Plan:
- Independent pair. RdD1 = 5, Rs1D2 = 6, Rs2D2 = 7, RdD2 = 8, all valid -> IssueP1 = IssueP2 = 1, stalls 0, SplitCount stays 0.
- RAW. RdD1 = 5, UsesRs2D2 = 1, Rs2D2 = 5 -> cycle 0: IssueP1 = 1, StallPipeline2 = StallFetch = 1. Cycle 1: IssueP2 = 1, StallPipeline1 = 1. Cycle 2: back in PAIR; SplitCount = 1.
- x0 and WAW. RdD1 = 0 = RdD2 with RegWrite set -> no split. RdD1 = RdD2 = 9 -> split, SplitCount += 1.
- StallExt for 3 cycles in SPLIT -> all Issue 0, all stalls 1 for 3 cycles, then IssueP2 = 1 and return to PAIR.
- Flush together with dep in PAIR -> Issue* = 0, state stays PAIR, SplitCount unchanged. Flush in SPLIT -> IssueP2 = 0, next PAIR.
- Reset and saturation. Assert rst asynchronously mid-SPLIT -> outputs 0 immediately, PAIR on release. Preload the counter near the top with CNT_W = 2 and run 5 dependent pairs -> SplitCount saturates at 3.

Source files
------------

// File: rtl/dual_issue_pkg.sv
// Shared types and constants for the dual-issue sequencer slice.
//   seq_state_t : pair-issue FSM states
//   REG_ZERO    : architectural zero register index (never a dependency)
//   REG_AW_DEF  : default register-index width
//   CNT_W_DEF   : default split-counter width
package dual_issue_pkg;

    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned REG_ZERO   = 0;

    typedef enum logic {
        PAIR  = 1'b0,
        SPLIT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/dual_issue_sequencer_if.sv
// Decode-slot pair / issue-control bundle between decode and the sequencer.
//   master : decode side (drives slot fields, StallExt, Flush; reads controls)
//   slave  : sequencer (reads slot fields; drives Issue*, Stall*, SplitCount)
interface dual_issue_sequencer_if
    import dual_issue_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
);

    logic              ValidD1;
    logic              ValidD2;
    logic              RegWriteD1;
    logic [REG_AW-1:0] RdD1;
    logic              RegWriteD2;
    logic [REG_AW-1:0] RdD2;
    logic [REG_AW-1:0] Rs1D2;
    logic [REG_AW-1:0] Rs2D2;
    logic              UsesRs1D2;
    logic              UsesRs2D2;
    logic              StallExt;
    logic              Flush;

    logic              IssueP1;
    logic              IssueP2;
    logic              StallPipeline1;
    logic              StallPipeline2;
    logic              StallFetch;
    logic [CNT_W-1:0]  SplitCount;

    modport master (
        output ValidD1, ValidD2, RegWriteD1, RdD1, RegWriteD2, RdD2,
               Rs1D2, Rs2D2, UsesRs1D2, UsesRs2D2, StallExt, Flush,
        input  IssueP1, IssueP2, StallPipeline1, StallPipeline2,
               StallFetch, SplitCount
    );

    modport slave (
        input  ValidD1, ValidD2, RegWriteD1, RdD1, RegWriteD2, RdD2,
               Rs1D2, Rs2D2, UsesRs1D2, UsesRs2D2, StallExt, Flush,
        output IssueP1, IssueP2, StallPipeline1, StallPipeline2,
               StallFetch, SplitCount
    );

endinterface

// File: rtl/pair_hazard_detect.sv
// Intra-pair dependency check: does slot 2 depend on slot 1's destination?
//   inputs : slot valids, slot 1 write/dest, slot 2 write/dest/sources/use bits
//   raw1_o : slot 2 source 1 matches slot 1 destination
//   raw2_o : slot 2 source 2 matches slot 1 destination
//   waw_o  : slot 2 writes the same destination as slot 1
//   dep_o  : qualified dependency (both valid, slot 1 writes a non-zero reg)
module pair_hazard_detect
    import dual_issue_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              valid1_i,
    input  logic              valid2_i,
    input  logic              reg_write1_i,
    input  logic [REG_AW-1:0] rd1_i,
    input  logic              reg_write2_i,
    input  logic [REG_AW-1:0] rd2_i,
    input  logic [REG_AW-1:0] rs1_2_i,
    input  logic [REG_AW-1:0] rs2_2_i,
    input  logic              uses_rs1_2_i,
    input  logic              uses_rs2_2_i,
    output logic              raw1_o,
    output logic              raw2_o,
    output logic              waw_o,
    output logic              dep_o
);

    assign raw1_o = uses_rs1_2_i & (rs1_2_i == rd1_i);
    assign raw2_o = uses_rs2_2_i & (rs2_2_i == rd1_i);
    assign waw_o  = reg_write2_i & (rd2_i == rd1_i);

    // Writes to x0 are discarded, so they can never create a dependency.
    assign dep_o = valid1_i & valid2_i & reg_write1_i &
                   (rd1_i != REG_AW'(REG_ZERO)) &
                   (raw1_o | raw2_o | waw_o);

endmodule

// File: rtl/dual_issue_sequencer.sv
// Issue/stall sequencer for the decode slot pair of the dual-issue core.
// Independent pairs issue together; a dependent pair is split over two
// cycles (slot 1 first, then slot 2 alone) while fetch holds.
//   clk, rst : core clock, asynchronous active-high reset
//   bus      : slave side of the slot-pair / issue-control bundle
// Issue and stall controls are combinational from state and inputs;
// SplitCount is a registered saturating count of split pairs.
module dual_issue_sequencer
    import dual_issue_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    dual_issue_sequencer_if.slave bus
);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] split_cnt_q, split_cnt_d;

    logic hz_raw1, hz_raw2, hz_waw, hz_dep;
    logic dep_c;

    logic issue1_c, issue2_c;
    logic stall1_c, stall2_c, stall_fetch_c;

    // Hazard detection on the current decode pair
    pair_hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .valid1_i     (bus.ValidD1),
        .valid2_i     (bus.ValidD2),
        .reg_write1_i (bus.RegWriteD1),
        .rd1_i        (bus.RdD1),
        .reg_write2_i (bus.RegWriteD2),
        .rd2_i        (bus.RdD2),
        .rs1_2_i      (bus.Rs1D2),
        .rs2_2_i      (bus.Rs2D2),
        .uses_rs1_2_i (bus.UsesRs1D2),
        .uses_rs2_2_i (bus.UsesRs2D2),
        .raw1_o       (hz_raw1),
        .raw2_o       (hz_raw2),
        .waw_o        (hz_waw),
        .dep_o        (hz_dep)
    );

    // Dependency qualified by the individual hazard flags
    assign dep_c = hz_dep & (hz_raw1 | hz_raw2 | hz_waw);

    // State and split-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PAIR;
            split_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            split_cnt_q <= split_cnt_d;
        end
    end

    // Next-state, counter and issue/stall decode; priority rst > Flush > StallExt
    always_comb begin
        state_d       = state_q;
        split_cnt_d   = split_cnt_q;
        issue1_c      = 1'b0;
        issue2_c      = 1'b0;
        stall1_c      = 1'b0;
        stall2_c      = 1'b0;
        stall_fetch_c = 1'b0;

        if (rst) begin
            state_d = PAIR;
        end else if (bus.Flush) begin
            // Redirect drops both decode slots, including a held slot 2
            state_d = PAIR;
        end else if (bus.StallExt) begin
            stall1_c      = 1'b1;
            stall2_c      = 1'b1;
            stall_fetch_c = 1'b1;
        end else begin
            unique case (state_q)
                PAIR: begin
                    if (dep_c) begin
                        issue1_c      = 1'b1;
                        stall2_c      = 1'b1;
                        stall_fetch_c = 1'b1;
                        state_d       = SPLIT;
                        if (split_cnt_q != '1) begin
                            split_cnt_d = split_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        issue1_c = bus.ValidD1;
                        issue2_c = bus.ValidD2;
                    end
                end
                SPLIT: begin
                    // Second half of a split pair; dep is not re-evaluated
                    issue2_c = bus.ValidD2;
                    stall1_c = 1'b1;
                    state_d  = PAIR;
                end
                default: begin
                    state_d = PAIR;
                end
            endcase
        end
    end

    assign bus.IssueP1        = issue1_c;
    assign bus.IssueP2        = issue2_c;
    assign bus.StallPipeline1 = stall1_c;
    assign bus.StallPipeline2 = stall2_c;
    assign bus.StallFetch     = stall_fetch_c;
    assign bus.SplitCount     = split_cnt_q;

endmodule

// File: tb/tb_dual_issue_sequencer.sv
// Self-checking bench for dual_issue_sequencer: directed scenarios followed by
// randomized pairs, compared against a behavioural model of pair splitting.
// A second instance with a 2-bit counter runs the same stimulus for saturation.
module tb_dual_issue_sequencer;
    import dual_issue_pkg::*;

    typedef struct packed {
        logic       v1;
        logic       v2;
        logic       rw1;
        logic [4:0] rd1;
        logic       rw2;
        logic [4:0] rd2;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       stall;
        logic       flush;
    } stim_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dual_issue_sequencer_if #(.REG_AW(5), .CNT_W(16)) bus   ();
    dual_issue_sequencer_if #(.REG_AW(5), .CNT_W(2))  bus_s ();

    assign bus_s.ValidD1    = bus.ValidD1;
    assign bus_s.ValidD2    = bus.ValidD2;
    assign bus_s.RegWriteD1 = bus.RegWriteD1;
    assign bus_s.RdD1       = bus.RdD1;
    assign bus_s.RegWriteD2 = bus.RegWriteD2;
    assign bus_s.RdD2       = bus.RdD2;
    assign bus_s.Rs1D2      = bus.Rs1D2;
    assign bus_s.Rs2D2      = bus.Rs2D2;
    assign bus_s.UsesRs1D2  = bus.UsesRs1D2;
    assign bus_s.UsesRs2D2  = bus.UsesRs2D2;
    assign bus_s.StallExt   = bus.StallExt;
    assign bus_s.Flush      = bus.Flush;

    dual_issue_sequencer #(.REG_AW(5), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dual_issue_sequencer #(.REG_AW(5), .CNT_W(2)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: whether slot 2 of a split pair is still waiting, and splits so far
    bit m_held = 1'b0;
    int m_cnt  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic stim_t mk(input bit v1, input bit v2, input bit rw1, input logic [4:0] rd1,
                                 input bit rw2, input logic [4:0] rd2, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input bit u1, input bit u2,
                                 input bit stall, input bit flush);
        stim_t s;
        s = '{v1, v2, rw1, rd1, rw2, rd2, rs1, rs2, u1, u2, stall, flush};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.ValidD1    = s.v1;
        bus.ValidD2    = s.v2;
        bus.RegWriteD1 = s.rw1;
        bus.RdD1       = s.rd1;
        bus.RegWriteD2 = s.rw2;
        bus.RdD2       = s.rd2;
        bus.Rs1D2      = s.rs1;
        bus.Rs2D2      = s.rs2;
        bus.UsesRs1D2  = s.u1;
        bus.UsesRs2D2  = s.u2;
        bus.StallExt   = s.stall;
        bus.Flush      = s.flush;
    endtask

    function automatic logic [4:0] ctl_main();
        return {bus.IssueP1, bus.IssueP2, bus.StallPipeline1, bus.StallPipeline2, bus.StallFetch};
    endfunction

    function automatic logic [4:0] ctl_sat();
        return {bus_s.IssueP1, bus_s.IssueP2, bus_s.StallPipeline1, bus_s.StallPipeline2, bus_s.StallFetch};
    endfunction

    task automatic check_counts(input string tag);
        check_eq({tag, ".cnt"},  32'(bus.SplitCount),   32'((m_cnt > 65535) ? 65535 : m_cnt));
        check_eq({tag, ".cnt2"}, 32'(bus_s.SplitCount), 32'((m_cnt > 3) ? 3 : m_cnt));
    endtask

    // One clock cycle: drive, check mid-cycle against the model, advance on the edge
    task automatic step(input stim_t s, input string tag);
        bit         dep;
        bit         nheld;
        bit         inc;
        logic [4:0] e;
        apply(s);
        #4;
        dep = s.v1 && s.v2 && s.rw1 && (s.rd1 != 5'd0) &&
              ((s.u1 && s.rs1 == s.rd1) || (s.u2 && s.rs2 == s.rd1) || (s.rw2 && s.rd2 == s.rd1));
        nheld = m_held;
        inc   = 1'b0;
        // e = {IssueP1, IssueP2, StallPipeline1, StallPipeline2, StallFetch}
        if (s.flush) begin
            e     = 5'b00000;
            nheld = 1'b0;
        end else if (s.stall) begin
            e = 5'b00111;
        end else if (m_held) begin
            e     = {1'b0, s.v2, 1'b1, 1'b0, 1'b0};
            nheld = 1'b0;
        end else if (dep) begin
            e     = 5'b10011;
            nheld = 1'b1;
            inc   = 1'b1;
        end else begin
            e = {s.v1, s.v2, 3'b000};
        end
        check_eq({tag, ".ctl"},  32'(ctl_main()), 32'(e));
        check_eq({tag, ".ctl2"}, 32'(ctl_sat()),  32'(e));
        check_counts(tag);
        @(posedge clk);
        #1;
        m_held = nheld;
        if (inc) m_cnt++;
    endtask

    stim_t s_idle, s_ind, s_raw, s_x0, s_waw, s_only1, s_only2, s_r;

    initial begin
        s_idle  = mk(0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        s_ind   = mk(1, 1, 1, 5'd5, 1, 5'd8, 5'd6, 5'd7, 1, 1, 0, 0);
        s_raw   = mk(1, 1, 1, 5'd5, 1, 5'd8, 5'd6, 5'd5, 0, 1, 0, 0);
        s_x0    = mk(1, 1, 1, 5'd0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0);
        s_waw   = mk(1, 1, 1, 5'd9, 1, 5'd9, 5'd1, 5'd2, 1, 1, 0, 0);
        s_only1 = mk(1, 0, 1, 5'd5, 1, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0);
        s_only2 = mk(0, 1, 1, 5'd5, 1, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0);

        // Reset state
        rst = 1'b1;
        apply(s_ind);
        #3;
        check_eq("reset.ctl", 32'(ctl_main()), 32'd0);
        check_counts("reset");
        apply(s_idle);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Independent pair, x0 never a dependency, RAW split
        step(s_ind, "ind");
        step(s_x0, "x0");
        step(s_raw, "raw.c0");
        step(s_ind, "raw.c1");
        check_eq("raw.cnt_one", 32'(bus.SplitCount), 32'd1);
        step(s_ind, "raw.c2");

        // WAW split, then back-to-back dependent pairs with no idle cycle
        step(s_waw, "waw.c0");
        step(s_waw, "waw.c1");
        step(s_raw, "b2b.c0");
        step(s_raw, "b2b.c1");

        // Single-slot validity
        step(s_only1, "only1");
        step(s_only2, "only2");

        // External stall held for three cycles during SPLIT
        step(s_raw, "stl.c0");
        s_r = s_ind;
        s_r.stall = 1'b1;
        for (int i = 0; i < 3; i++) step(s_r, $sformatf("stl.h%0d", i));
        step(s_ind, "stl.rel");
        step(s_ind, "stl.pair");

        // Flush with dep in PAIR, flush in SPLIT, flush with stall
        s_r = s_raw;
        s_r.flush = 1'b1;
        step(s_r, "fl.pair");
        step(s_raw, "fl.s0");
        step(s_r, "fl.split");
        s_r.stall = 1'b1;
        step(s_r, "fl.stall");
        step(s_ind, "fl.after");

        // Saturation of the 2-bit counter over five dependent pairs
        for (int i = 0; i < 5; i++) begin
            step(s_raw, $sformatf("sat%0d.a", i));
            step(s_raw, $sformatf("sat%0d.b", i));
        end
        check_eq("sat.cnt2_top", 32'(bus_s.SplitCount), 32'd3);

        // Asynchronous reset in the middle of SPLIT
        step(s_raw, "ar.c0");
        apply(s_ind);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar.async.ctl", 32'(ctl_main()), 32'd0);
        check_eq("ar.async.cnt", 32'(bus.SplitCount), 32'd0);
        check_eq("ar.async.cnt2", 32'(bus_s.SplitCount), 32'd0);
        apply(s_idle);
        @(posedge clk);
        #1;
        check_eq("ar.hold.ctl", 32'(ctl_main()), 32'd0);
        #2;
        rst    = 1'b0;
        m_held = 1'b0;
        m_cnt  = 0;
        step(s_ind, "ar.pair");

        // Randomized pairs on a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            s_r.v1    = ($urandom_range(0, 7) != 0);
            s_r.v2    = ($urandom_range(0, 7) != 0);
            s_r.rw1   = ($urandom_range(0, 3) != 0);
            s_r.rw2   = ($urandom_range(0, 1) != 0);
            s_r.rd1   = 5'($urandom_range(0, 3));
            s_r.rd2   = 5'($urandom_range(0, 3));
            s_r.rs1   = 5'($urandom_range(0, 3));
            s_r.rs2   = 5'($urandom_range(0, 3));
            s_r.u1    = ($urandom_range(0, 1) != 0);
            s_r.u2    = ($urandom_range(0, 1) != 0);
            s_r.stall = ($urandom_range(0, 7) == 0);
            s_r.flush = ($urandom_range(0, 9) == 0);
            step(s_r, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
